// File: rtl/fir_router_pkg.sv
// fir_router_pkg: shared FSM states, idle channel values and the activity predicate for the FIR channel router.
package fir_router_pkg;
    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, SWITCH} stateT;
    localparam int CNT_W = 4;
    localparam logic CSN_IDLE = 1'b1;
    localparam logic WRN_IDLE = 1'b1;
    localparam logic EN_IDLE = 1'b0;
    localparam logic ADDR_IDLE_BIT = 1'b0;
    localparam logic DATA_IDLE_BIT = 1'b0;
    function automatic logic isActivity(input logic csn, input logic mul, input logic acc);
        return ~csn | mul | acc;
    endfunction
endpackage

// File: rtl/fir_channel_router_if.sv
// fir_channel_router_if: control stream, select handshake and per-channel outputs of the FIR channel router.
interface fir_channel_router_if #(
    parameter int NUM_CH = 4,
    parameter int SEL_W = 2,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
);
    logic [SEL_W-1:0] iModuleSel;
    logic iSelValid;
    logic oSelReady;
    logic iBroadcast;
    logic iCsnRam;
    logic iWrnRam;
    logic [ADDR_W-1:0] iAddrRam;
    logic [DATA_W-1:0] iWtDtRam;
    logic iEnMul;
    logic iEnAddAcc;
    logic [NUM_CH-1:0] oCsnRam;
    logic [NUM_CH-1:0] oWrnRam;
    logic [NUM_CH*ADDR_W-1:0] oAddrRam;
    logic [NUM_CH*DATA_W-1:0] oWtDtRam;
    logic [NUM_CH-1:0] oEnMul;
    logic [NUM_CH-1:0] oEnAddAcc;
    logic [SEL_W-1:0] oActiveSel;
    logic oBusy;
    logic oErr;
    modport master (
        output iModuleSel, iSelValid, iBroadcast, iCsnRam, iWrnRam, iAddrRam, iWtDtRam, iEnMul, iEnAddAcc,
        input oSelReady, oCsnRam, oWrnRam, oAddrRam, oWtDtRam, oEnMul, oEnAddAcc, oActiveSel, oBusy, oErr
    );
    modport slave (
        input iModuleSel, iSelValid, iBroadcast, iCsnRam, iWrnRam, iAddrRam, iWtDtRam, iEnMul, iEnAddAcc,
        output oSelReady, oCsnRam, oWrnRam, oAddrRam, oWtDtRam, oEnMul, oEnAddAcc, oActiveSel, oBusy, oErr
    );
endinterface

// File: rtl/fir_router_ctrl.sv
// fir_router_ctrl: switch FSM, drain counter and pending-select register; a channel change waits for the MAC pipe to drain.
module fir_router_ctrl
    import fir_router_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int SEL_W = 2,
    parameter int DRAIN_CYC = 2
) (
    input  logic iClk,
    input  logic iRsn,
    input  logic [SEL_W-1:0] iModuleSel,
    input  logic iSelValid,
    input  logic iAct,
    output logic oSelReady,
    output logic [SEL_W-1:0] oActiveSel,
    output logic oSwitch,
    output logic oErr
);
    stateT state, nextState;
    logic [CNT_W-1:0] cnt, nextCnt;
    logic pendValid;
    logic [SEL_W-1:0] pendSel;
    logic reqOk;

    assign reqOk = 32'(iModuleSel) < NUM_CH;
    assign oSelReady = ~pendValid;
    assign oSwitch = state == SWITCH;

    always_comb begin
        nextState = state;
        nextCnt = cnt;
        case (state)
            IDLE: nextState = pendValid ? SWITCH : iAct ? ACTIVE : IDLE;
            ACTIVE: if (!iAct) begin
                nextState = DRAIN_CYC == 0 ? IDLE : DRAIN;
                nextCnt = CNT_W'(DRAIN_CYC - 1);
            end
            DRAIN: begin
                nextState = iAct ? ACTIVE : cnt == '0 ? IDLE : DRAIN;
                nextCnt = (!iAct && cnt != '0) ? cnt - 1'b1 : cnt;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRsn)
        if (!iRsn) begin
            state <= IDLE;
            cnt <= '0;
            pendValid <= 1'b0;
            pendSel <= '0;
            oActiveSel <= '0;
            oErr <= 1'b0;
        end else begin
            state <= nextState;
            cnt <= nextCnt;
            if (state == SWITCH) begin
                oActiveSel <= pendSel;
                pendValid <= 1'b0;
            end else if (iSelValid && !pendValid && reqOk) begin
                pendValid <= 1'b1;
                pendSel <= iModuleSel;
            end
            // out-of-range requests and traffic dropped during a switch are both sticky faults
            oErr <= oErr | (iSelValid & ~pendValid & ~reqOk) | (oSwitch & iAct);
        end
endmodule

// File: rtl/fir_channel_router.sv
// fir_channel_router: registered per-channel output mux routing one SRAM/MAC control stream to the active FIR channel.
module fir_channel_router
    import fir_router_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int SEL_W = 2,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16,
    parameter int DRAIN_CYC = 2
) (
    input logic iClk,
    input logic iRsn,
    fir_channel_router_if.slave bus
);
    logic act, bcast, switching;
    logic [SEL_W-1:0] activeSel;
    logic [NUM_CH-1:0] nCsn, nWrn, nMul, nAcc;
    logic [NUM_CH*ADDR_W-1:0] nAddr;
    logic [NUM_CH*DATA_W-1:0] nData;

    assign act = isActivity(bus.iCsnRam, bus.iEnMul, bus.iEnAddAcc);
    assign bcast = bus.iBroadcast & ~bus.iCsnRam & ~bus.iWrnRam;
    assign bus.oActiveSel = activeSel;
    assign bus.oBusy = switching;

    fir_router_ctrl #(.NUM_CH(NUM_CH), .SEL_W(SEL_W), .DRAIN_CYC(DRAIN_CYC)) ctrl (
        .iClk(iClk),
        .iRsn(iRsn),
        .iModuleSel(bus.iModuleSel),
        .iSelValid(bus.iSelValid),
        .iAct(act),
        .oSelReady(bus.oSelReady),
        .oActiveSel(activeSel),
        .oSwitch(switching),
        .oErr(bus.oErr)
    );

    // broadcast fans out the SRAM write only; MAC enables stay with the active channel
    always_comb begin
        nCsn = {NUM_CH{CSN_IDLE}};
        nWrn = {NUM_CH{WRN_IDLE}};
        nAddr = {NUM_CH*ADDR_W{ADDR_IDLE_BIT}};
        nData = {NUM_CH*DATA_W{DATA_IDLE_BIT}};
        nMul = {NUM_CH{EN_IDLE}};
        nAcc = {NUM_CH{EN_IDLE}};
        for (int k = 0; k < NUM_CH; k++) begin
            if (!switching && (int'(activeSel) == k || bcast)) begin
                nCsn[k] = bus.iCsnRam;
                nWrn[k] = bus.iWrnRam;
                nAddr[k*ADDR_W +: ADDR_W] = bus.iAddrRam;
                nData[k*DATA_W +: DATA_W] = bus.iWtDtRam;
            end
            if (!switching && int'(activeSel) == k) begin
                nMul[k] = bus.iEnMul;
                nAcc[k] = bus.iEnAddAcc;
            end
        end
    end

    always_ff @(posedge iClk or negedge iRsn)
        if (!iRsn) begin
            bus.oCsnRam <= {NUM_CH{CSN_IDLE}};
            bus.oWrnRam <= {NUM_CH{WRN_IDLE}};
            bus.oAddrRam <= {NUM_CH*ADDR_W{ADDR_IDLE_BIT}};
            bus.oWtDtRam <= {NUM_CH*DATA_W{DATA_IDLE_BIT}};
            bus.oEnMul <= {NUM_CH{EN_IDLE}};
            bus.oEnAddAcc <= {NUM_CH{EN_IDLE}};
        end else begin
            bus.oCsnRam <= nCsn;
            bus.oWrnRam <= nWrn;
            bus.oAddrRam <= nAddr;
            bus.oWtDtRam <= nData;
            bus.oEnMul <= nMul;
            bus.oEnAddAcc <= nAcc;
        end
endmodule

// File: tb/tb_fir_channel_router.sv
// tb_fir_channel_router: directed scoreboard bench for a 4-channel router plus a 3-channel instance for range errors.
module tb_fir_channel_router;
    typedef struct {
        string tag;
        logic [3:0] csn, wrn, mul, acc;
        logic [15:0] addr;
        logic [63:0] data;
    } expT;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    int nCmp = 0;
    int nFail = 0;
    int modelSel = 0;
    expT sb[$];

    fir_channel_router_if #(.NUM_CH(4), .SEL_W(2), .ADDR_W(4), .DATA_W(16)) bus ();
    fir_channel_router_if #(.NUM_CH(3), .SEL_W(2), .ADDR_W(4), .DATA_W(16)) bus3 ();

    fir_channel_router #(.NUM_CH(4), .SEL_W(2), .ADDR_W(4), .DATA_W(16), .DRAIN_CYC(2)) dut (
        .iClk(clk), .iRsn(rstN), .bus(bus.slave));
    fir_channel_router #(.NUM_CH(3), .SEL_W(2), .ADDR_W(4), .DATA_W(16), .DRAIN_CYC(2)) dut3 (
        .iClk(clk), .iRsn(rstN), .bus(bus3.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic setIn(input logic bc, input logic csn, input logic wrn, input logic [3:0] addr,
                         input logic [15:0] data, input logic mul, input logic acc);
        bus.iBroadcast = bc;
        bus.iCsnRam = csn;
        bus.iWrnRam = wrn;
        bus.iAddrRam = addr;
        bus.iWtDtRam = data;
        bus.iEnMul = mul;
        bus.iEnAddAcc = acc;
    endtask

    task automatic idleIn();
        setIn(1'b0, 1'b1, 1'b1, 4'h0, 16'h0, 1'b0, 1'b0);
    endtask

    // queue the expected channel image for the current inputs, clock once, then compare the oldest entry
    task automatic tick(input string tag, input bit idleOut);
        expT e;
        expT got;
        logic bc;
        bc = bus.iBroadcast & ~bus.iCsnRam & ~bus.iWrnRam;
        e.tag = tag;
        e.csn = 4'hF; e.wrn = 4'hF; e.mul = 4'h0; e.acc = 4'h0; e.addr = '0; e.data = '0;
        for (int k = 0; k < 4; k++) begin
            if (!idleOut && (k == modelSel || bc)) begin
                e.csn[k] = bus.iCsnRam;
                e.wrn[k] = bus.iWrnRam;
                e.addr[k*4 +: 4] = bus.iAddrRam;
                e.data[k*16 +: 16] = bus.iWtDtRam;
            end
            if (!idleOut && k == modelSel) begin
                e.mul[k] = bus.iEnMul;
                e.acc[k] = bus.iEnAddAcc;
            end
        end
        sb.push_back(e);
        @(negedge clk);
        got = sb.pop_front();
        check({got.tag, ".csn"}, 64'(bus.oCsnRam), 64'(got.csn));
        check({got.tag, ".wrn"}, 64'(bus.oWrnRam), 64'(got.wrn));
        check({got.tag, ".addr"}, 64'(bus.oAddrRam), 64'(got.addr));
        check({got.tag, ".data"}, bus.oWtDtRam, got.data);
        check({got.tag, ".mul"}, 64'(bus.oEnMul), 64'(got.mul));
        check({got.tag, ".acc"}, 64'(bus.oEnAddAcc), 64'(got.acc));
    endtask

    task automatic checkResetState(input string tag);
        check({tag, ".csn"}, 64'(bus.oCsnRam), 64'hF);
        check({tag, ".wrn"}, 64'(bus.oWrnRam), 64'hF);
        check({tag, ".addr"}, 64'(bus.oAddrRam), 64'h0);
        check({tag, ".data"}, bus.oWtDtRam, 64'h0);
        check({tag, ".en"}, 64'({bus.oEnMul, bus.oEnAddAcc}), 64'h0);
        check({tag, ".sel"}, 64'(bus.oActiveSel), 64'h0);
        check({tag, ".ready"}, 64'(bus.oSelReady), 64'h1);
        check({tag, ".busy"}, 64'(bus.oBusy), 64'h0);
        check({tag, ".err"}, 64'(bus.oErr), 64'h0);
    endtask

    initial begin
        int n;
        idleIn();
        bus.iModuleSel = '0;
        bus.iSelValid = 1'b0;
        bus3.iModuleSel = '0;
        bus3.iSelValid = 1'b0;
        bus3.iBroadcast = 1'b0;
        bus3.iCsnRam = 1'b1;
        bus3.iWrnRam = 1'b1;
        bus3.iAddrRam = '0;
        bus3.iWtDtRam = '0;
        bus3.iEnMul = 1'b0;
        bus3.iEnAddAcc = 1'b0;

        #12 checkResetState("inReset");
        @(negedge clk) rstN = 1'b1;
        tick("idle0", 0);
        tick("idle1", 0);
        checkResetState("afterReset");

        // deferred switch: channel 0 keeps its MAC traffic while a request for 3 waits
        setIn(1'b0, 1'b1, 1'b1, 4'h0, 16'h0, 1'b1, 1'b0);
        tick("mul0", 0);
        bus.iModuleSel = 2'd3;
        bus.iSelValid = 1'b1;
        tick("mul1", 0);
        bus.iSelValid = 1'b0;
        check("deferReady", 64'(bus.oSelReady), 64'h0);
        tick("mul2", 0);
        check("deferNoBusy", 64'(bus.oBusy), 64'h0);
        idleIn();
        n = 0;
        while (!bus.oBusy && n < 20) begin
            tick("drain", 0);
            n++;
        end
        check("switchDelay", 64'(n), 64'(2 + 2));
        check("switchOldSel", 64'(bus.oActiveSel), 64'h0);
        tick("switch3", 1);
        modelSel = 3;
        check("switchBusyLen", 64'(bus.oBusy), 64'h0);
        check("switchNewSel", 64'(bus.oActiveSel), 64'h3);

        // routed write to channel 2
        bus.iModuleSel = 2'd2;
        bus.iSelValid = 1'b1;
        tick("req2", 0);
        bus.iSelValid = 1'b0;
        tick("pend2", 0);
        check("busy2", 64'(bus.oBusy), 64'h1);
        tick("switch2", 1);
        modelSel = 2;
        check("sel2", 64'(bus.oActiveSel), 64'h2);
        check("ready2", 64'(bus.oSelReady), 64'h1);
        tick("gap", 0);
        setIn(1'b0, 1'b0, 1'b0, 4'h5, 16'hABCD, 1'b0, 1'b0);
        tick("write2", 0);
        idleIn();
        for (int i = 0; i < 4; i++) tick("drain2", 0);

        // broadcast write then broadcast read
        setIn(1'b1, 1'b0, 1'b0, 4'h1, 16'h0042, 1'b1, 1'b0);
        tick("bcastWrite", 0);
        setIn(1'b1, 1'b0, 1'b1, 4'h9, 16'h1234, 1'b0, 1'b1);
        tick("bcastRead", 0);
        idleIn();
        for (int i = 0; i < 4; i++) tick("drainBc", 0);
        check("errClear", 64'(bus.oErr), 64'h0);

        // out-of-range request on the 3-channel instance
        bus3.iModuleSel = 2'd3;
        bus3.iSelValid = 1'b1;
        tick("req3of3", 0);
        bus3.iSelValid = 1'b0;
        check("rangeReady", 64'(bus3.oSelReady), 64'h1);
        check("rangeErr", 64'(bus3.oErr), 64'h1);
        tick("range1", 0);
        check("rangeNoBusy", 64'(bus3.oBusy), 64'h0);
        check("rangeSel", 64'(bus3.oActiveSel), 64'h0);

        // traffic during SWITCH is dropped and flagged
        bus.iModuleSel = 2'd1;
        bus.iSelValid = 1'b1;
        tick("req1", 0);
        bus.iSelValid = 1'b0;
        tick("pend1", 0);
        check("busy1", 64'(bus.oBusy), 64'h1);
        setIn(1'b0, 1'b0, 1'b1, 4'h7, 16'h5555, 1'b0, 1'b0);
        tick("dropInSwitch", 1);
        modelSel = 1;
        check("dropErr", 64'(bus.oErr), 64'h1);
        check("sel1", 64'(bus.oActiveSel), 64'h1);

        // reset in DRAIN with a request pending
        tick("act1", 0);
        idleIn();
        bus.iModuleSel = 2'd2;
        bus.iSelValid = 1'b1;
        tick("reqInDrain", 0);
        bus.iSelValid = 1'b0;
        check("drainPending", 64'(bus.oSelReady), 64'h0);
        #2 rstN = 1'b0;
        #1 checkResetState("midReset");
        check("midReset3.err", 64'(bus3.oErr), 64'h0);
        @(negedge clk) rstN = 1'b1;
        modelSel = 0;
        for (int i = 0; i < 5; i++) begin
            tick("postReset", 0);
            check("postResetBusy", 64'(bus.oBusy), 64'h0);
        end
        check("postResetSel", 64'(bus.oActiveSel), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end
endmodule
